chrom_eval_engine: RTL and testbench
====================================

Name: chrom_eval_engine

Overview:
Parametrised successor of the fitness-evaluation state machine. It drives an evolved circuit (the phenotype instance sits outside this block) through up to SEQ_DEPTH stimulus vectors and holds each vector for a runtime-programmable number of cycles. After a settle window it samples the circuit output and accumulates per-output-bit error counts. New relative to the previous generation: generic widths, early abort on an error budget, saturating counters, a zero-length run case, and an optional trace-memory stream.

Parameters:
IN_W, 8, circuit input width
OUT_W, 8, circuit output width / number of error channels
SEQ_DEPTH, 64, maximum vectors per run
CNT_W, 32, error counter width
IGNORE_CYCLES, 5, settle cycles per vector excluded from sampling
ADDR_W, 15, trace address width

Ports:
iClock  in  1  clock
iResetN  in  1  reset, asynchronous, active-low
iStart  in  1  start pulse; honoured only in IDLE
iAck  in  1  result consumed; honoured only in DONE
iHoldCycles  in  16  cycles per vector; 0 is treated as 1
iSeqCount  in  $clog2(SEQ_DEPTH+1)  vectors to run
iMaxErrors  in  CNT_W+$clog2(OUT_W)  abort budget; 0 disables abort
iInputSeq  in  SEQ_DEPTH x IN_W  stimulus vectors
iExpected  in  SEQ_DEPTH x OUT_W  expected outputs
iValidMask  in  SEQ_DEPTH x OUT_W  1 = bit is checked
iCircuitOut  in  OUT_W  circuit output
oCircuitIn  out  IN_W  registered circuit input
oCircuitClear  out  1  zero circuit configuration
oReady  out  1  state==IDLE
oDone  out  1  state==DONE
oAborted  out  1  last run ended on budget
oErrorSums  out  OUT_W x CNT_W  per-bit vector-error counts
oTotalErrors  out  CNT_W+$clog2(OUT_W)  sum of oErrorSums, combinational
oState  out  3  encoded state
oTraceWr, oTraceAddr[ADDR_W], oTraceData[32]  out  trace stream

Behaviour:
- Reset: state IDLE; all counters, sums, oCircuitIn, oAborted, trace address = 0; oCircuitClear = 0.
- IDLE: when iStart=1, clear sums, clear oAborted, set index=0, go to CLEAR.
- CLEAR: oCircuitClear=1 for exactly one cycle. If iSeqCount==0, go to DONE. Otherwise go to SETTLE.
- SETTLE: 1 cycle. oCircuitIn <= iInputSeq[index]; cycle counter=0; per-bit mismatch flags cleared; go to HOLD.
- HOLD: lasts H = max(iHoldCycles,1) cycles, counter 0..H-1.
  - When counter >= IGNORE_CYCLES, set flag[b] if (iCircuitOut[b] ^ iExpected[index][b]) & iValidMask[index][b]. Flags are sticky.
  - At counter==H-1, the flags include that cycle's sample. Each oErrorSums[b] += flag[b], saturating at 2^CNT_W-1.
  - Then: if iMaxErrors!=0 and the updated total >= iMaxErrors, set oAborted=1 and go to DONE. Else if index==iSeqCount-1, go to DONE. Else index++ and go to SETTLE.
- DONE: holds results. iAck returns to IDLE. oDone is high for at least one cycle, because iAck is sampled only in DONE.
- Latency: oDone rises 1+N*(1+H) edges after the edge that samples iStart.
- IGNORE_CYCLES >= H: no samples are taken, so zero errors.
- iStart outside IDLE and iAck outside DONE are ignored.
- iInputSeq, iExpected, iValidMask, iSeqCount, iHoldCycles and iMaxErrors are read live and must be stable for the whole run.
- Reset mid-run: immediate return to IDLE, sums zeroed.
- Results remain readable in IDLE until the next start.

Optional Feature:
CHROM_EVAL_TRACE_EN.
- Defined: oTraceWr=1 on every HOLD cycle.
  - oTraceData = {oCircuitIn zero-padded/truncated to 8, index zero-padded to 8, iExpected[index][7:0], iCircuitOut[7:0]}; narrower fields are zero-padded.
  - oTraceAddr is 0 at the first write of a run, increments after each write and wraps modulo 2^ADDR_W.
- Undefined: the trace ports exist but are tied to 0, and no trace logic is generated.

Decomposition:
- Package chrom_eval_pkg holds:
  - the state enum (IDLE=0, CLEAR=1, SETTLE=2, HOLD=3, DONE=4);
  - a saturating-add function;
  - default parameter constants.
- One sub-module, chrom_eval_err_channel: per-bit sticky mismatch flag plus saturating counter, instantiated OUT_W times via generate.

Test Plan:
- N=4, H=10, output always equals expected, no abort -> all sums 0, oTotalErrors=0, oDone rises exactly 45 edges after start, oAborted=0.
- Output bit 3 inverted during vector 2 only, mask all ones -> oErrorSums[3]=1, others 0, total 1.
- IGNORE_CYCLES=5, H=10, mismatch on counter 0..4 only -> 0 errors; same mismatch on counter 5 only -> 1 error on that bit.
- iValidMask bit 0 = 0 for all vectors, bit 0 always wrong, N=4 -> oErrorSums[0]=0.
- iMaxErrors=2, all 8 bits wrong, N=4 -> DONE after vector 0, oAborted=1, every sum=1, total 8.
- iSeqCount=0 -> CLEAR then DONE, sums 0. Separately, deassert iResetN mid-HOLD -> IDLE, oReady=1, sums 0. With CHROM_EVAL_TRACE_EN, N=2, H=3 -> 6 writes at addresses 0..5.

Source files
------------

// File: rtl/chrom_eval_pkg.sv
// rtl/chrom_eval_pkg.sv - shared state encoding, defaults and saturating add for the evaluation engine
package chrom_eval_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_DONE   = 3'd4
  } eval_state_t;

  localparam int DEF_IN_W          = 8;
  localparam int DEF_OUT_W         = 8;
  localparam int DEF_SEQ_DEPTH     = 64;
  localparam int DEF_CNT_W         = 32;
  localparam int DEF_IGNORE_CYCLES = 5;
  localparam int DEF_ADDR_W        = 15;

  // Callers pass their own ceiling so one function serves any counter width up to 64.
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input logic [63:0] max_val);
    logic [64:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, max_val}) ? max_val : s[63:0];
  endfunction

endpackage

// File: rtl/chrom_eval_err_channel.sv
// rtl/chrom_eval_err_channel.sv - one output bit: sticky per-vector mismatch flag and saturating error count
module chrom_eval_err_channel
  import chrom_eval_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_sum,
  input  logic             clear_flag,
  input  logic             sample,
  input  logic             mismatch,
  input  logic             commit,
  output logic [CNT_W-1:0] sum,
  output logic [CNT_W-1:0] sum_next
);

  localparam logic [63:0] SAT_MAX = (64'(1) << CNT_W) - 64'(1);

  logic flag;
  logic flag_now;

  // The last HOLD cycle's own sample must count, so commit uses the look-ahead flag.
  assign flag_now = flag | (sample & mismatch);
  assign sum_next = CNT_W'(sat_add(64'(sum), 64'(flag_now), SAT_MAX));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag <= 1'b0;
      sum  <= '0;
    end else begin
      if (clear_sum) begin
        sum <= '0;
      end else if (commit) begin
        sum <= sum_next;
      end
      if (clear_flag) begin
        flag <= 1'b0;
      end else begin
        flag <= flag_now;
      end
    end
  end

endmodule

// File: rtl/chrom_eval_engine.sv
// rtl/chrom_eval_engine.sv - fitness-evaluation sequencer; define CHROM_EVAL_TRACE_EN for the trace stream
module chrom_eval_engine
  import chrom_eval_pkg::*;
#(
  parameter int IN_W          = DEF_IN_W,
  parameter int OUT_W         = DEF_OUT_W,
  parameter int SEQ_DEPTH     = DEF_SEQ_DEPTH,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int IGNORE_CYCLES = DEF_IGNORE_CYCLES,
  parameter int ADDR_W        = DEF_ADDR_W
) (
  input  logic                                  iClock,
  input  logic                                  iResetN,
  input  logic                                  iStart,
  input  logic                                  iAck,
  input  logic [15:0]                           iHoldCycles,
  input  logic [$clog2(SEQ_DEPTH+1)-1:0]        iSeqCount,
  input  logic [CNT_W+$clog2(OUT_W)-1:0]        iMaxErrors,
  input  logic [SEQ_DEPTH-1:0][IN_W-1:0]        iInputSeq,
  input  logic [SEQ_DEPTH-1:0][OUT_W-1:0]       iExpected,
  input  logic [SEQ_DEPTH-1:0][OUT_W-1:0]       iValidMask,
  input  logic [OUT_W-1:0]                      iCircuitOut,
  output logic [IN_W-1:0]                       oCircuitIn,
  output logic                                  oCircuitClear,
  output logic                                  oReady,
  output logic                                  oDone,
  output logic                                  oAborted,
  output logic [OUT_W-1:0][CNT_W-1:0]           oErrorSums,
  output logic [CNT_W+$clog2(OUT_W)-1:0]        oTotalErrors,
  output logic [2:0]                            oState,
  output logic                                  oTraceWr,
  output logic [ADDR_W-1:0]                     oTraceAddr,
  output logic [31:0]                           oTraceData
);

  localparam int SEQ_W = $clog2(SEQ_DEPTH + 1);
  localparam int IDX_W = (SEQ_DEPTH > 1) ? $clog2(SEQ_DEPTH) : 1;
  localparam int TOT_W = CNT_W + $clog2(OUT_W);
  localparam logic [15:0] IGNORE_LIMIT = 16'(IGNORE_CYCLES);

  eval_state_t state, state_next;

  logic [IDX_W-1:0]              index;
  logic [15:0]                   hold_cnt;
  logic [15:0]                   hold_len;
  logic                          last_cycle;
  logic                          last_vec;
  logic                          start_run;
  logic                          settle_en;
  logic                          sample_en;
  logic                          commit;
  logic                          budget_hit;
  logic [OUT_W-1:0]              mismatch;
  logic [OUT_W-1:0][CNT_W-1:0]   sum_next;
  logic [TOT_W-1:0]              total_next;

  assign hold_len   = (iHoldCycles == 16'd0) ? 16'd1 : iHoldCycles;
  assign last_cycle = (hold_cnt == hold_len - 16'd1);
  // An over-range iSeqCount stops at the last stored vector instead of wrapping.
  assign last_vec   = (SEQ_W'(index) == iSeqCount - SEQ_W'(1)) ||
                      (index == IDX_W'(SEQ_DEPTH - 1));
  assign start_run  = (state == ST_IDLE) && iStart;
  assign settle_en  = (state == ST_SETTLE);
  assign sample_en  = (state == ST_HOLD) && (hold_cnt >= IGNORE_LIMIT);
  assign commit     = (state == ST_HOLD) && last_cycle;
  assign mismatch   = (iCircuitOut ^ iExpected[index]) & iValidMask[index];
  assign budget_hit = (iMaxErrors != '0) && (total_next >= iMaxErrors);

  always_comb begin
    total_next   = '0;
    oTotalErrors = '0;
    for (int b = 0; b < OUT_W; b++) begin
      total_next   = total_next + TOT_W'(sum_next[b]);
      oTotalErrors = oTotalErrors + TOT_W'(oErrorSums[b]);
    end
  end

  for (genvar b = 0; b < OUT_W; b++) begin : g_chan
    chrom_eval_err_channel #(
      .CNT_W(CNT_W)
    ) u_chan (
      .clk       (iClock),
      .rst_n     (iResetN),
      .clear_sum (start_run),
      .clear_flag(settle_en),
      .sample    (sample_en),
      .mismatch  (mismatch[b]),
      .commit    (commit),
      .sum       (oErrorSums[b]),
      .sum_next  (sum_next[b])
    );
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (iStart) state_next = ST_CLEAR;
      ST_CLEAR:  state_next = (iSeqCount == '0) ? ST_DONE : ST_SETTLE;
      ST_SETTLE: state_next = ST_HOLD;
      ST_HOLD: begin
        if (last_cycle) begin
          state_next = (budget_hit || last_vec) ? ST_DONE : ST_SETTLE;
        end
      end
      ST_DONE:   if (iAck) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      index      <= '0;
      hold_cnt   <= '0;
      oCircuitIn <= '0;
      oAborted   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (iStart) begin
            index    <= '0;
            oAborted <= 1'b0;
          end
        end
        ST_SETTLE: begin
          oCircuitIn <= iInputSeq[index];
          hold_cnt   <= '0;
        end
        ST_HOLD: begin
          if (last_cycle) begin
            if (budget_hit) begin
              oAborted <= 1'b1;
            end else if (!last_vec) begin
              index <= index + IDX_W'(1);
            end
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign oCircuitClear = (state == ST_CLEAR);
  assign oReady        = (state == ST_IDLE);
  assign oDone         = (state == ST_DONE);
  assign oState        = state;

`ifdef CHROM_EVAL_TRACE_EN
  logic [ADDR_W-1:0] trace_addr;

  always_ff @(posedge iClock or negedge iResetN) begin
    if (!iResetN) begin
      trace_addr <= '0;
    end else if (start_run) begin
      trace_addr <= '0;
    end else if (state == ST_HOLD) begin
      trace_addr <= trace_addr + ADDR_W'(1);
    end
  end

  assign oTraceWr   = (state == ST_HOLD);
  assign oTraceAddr = trace_addr;
  assign oTraceData = {8'(oCircuitIn), 8'(index), 8'(iExpected[index]), 8'(iCircuitOut)};
`else
  assign oTraceWr   = 1'b0;
  assign oTraceAddr = '0;
  assign oTraceData = '0;
`endif

endmodule

// File: tb/tb_chrom_eval_engine.sv
// tb/tb_chrom_eval_engine.sv - self-checking bench for chrom_eval_engine
module tb_chrom_eval_engine;

  localparam int IN_W      = 8;
  localparam int OUT_W     = 8;
  localparam int SEQ_DEPTH = 64;
  localparam int CNT_W     = 32;
  localparam int IGN       = 5;
  localparam int ADDR_W    = 15;
  localparam int SEQ_W     = $clog2(SEQ_DEPTH + 1);
  localparam int TOT_W     = CNT_W + $clog2(OUT_W);
  localparam int MAXH      = 16;
  localparam longint SAT   = 64'hFFFF_FFFF;

  typedef struct {
    int         n;
    int         h;
    longint     mx;
    int         inj_vec;
    int         lo;
    int         hi;
    logic [7:0] bits;
    logic [7:0] mask;
    logic [7:0] e_bits;
    int         e_sum;
    longint     e_total;
    int         e_ab;
    int         e_lat;
    int         e_last;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                              rst_n;
  logic                              start;
  logic                              ack;
  logic [15:0]                       hold;
  logic [SEQ_W-1:0]                  seq_count;
  logic [TOT_W-1:0]                  max_err;
  logic [SEQ_DEPTH-1:0][IN_W-1:0]    in_seq;
  logic [SEQ_DEPTH-1:0][OUT_W-1:0]   exp_seq;
  logic [SEQ_DEPTH-1:0][OUT_W-1:0]   mask_seq;
  logic [OUT_W-1:0]                  circ_out;
  logic [IN_W-1:0]                   circ_in;
  logic                              circ_clear;
  logic                              ready;
  logic                              done;
  logic                              aborted;
  logic [OUT_W-1:0][CNT_W-1:0]       sums;
  logic [TOT_W-1:0]                  total;
  logic [2:0]                        state;
  logic                              trace_wr;
  logic [ADDR_W-1:0]                 trace_addr;
  logic [31:0]                       trace_data;

  chrom_eval_engine #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SEQ_DEPTH(SEQ_DEPTH),
    .CNT_W(CNT_W), .IGNORE_CYCLES(IGN), .ADDR_W(ADDR_W)
  ) dut (
    .iClock(clk), .iResetN(rst_n), .iStart(start), .iAck(ack),
    .iHoldCycles(hold), .iSeqCount(seq_count), .iMaxErrors(max_err),
    .iInputSeq(in_seq), .iExpected(exp_seq), .iValidMask(mask_seq),
    .iCircuitOut(circ_out), .oCircuitIn(circ_in), .oCircuitClear(circ_clear),
    .oReady(ready), .oDone(done), .oAborted(aborted), .oErrorSums(sums),
    .oTotalErrors(total), .oState(state), .oTraceWr(trace_wr),
    .oTraceAddr(trace_addr), .oTraceData(trace_data)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] in_v    [SEQ_DEPTH];
  logic [7:0] exp_v   [SEQ_DEPTH];
  logic [7:0] mask_v  [SEQ_DEPTH];
  logic [7:0] corrupt [SEQ_DEPTH][MAXH];
  int     cfg_n, cfg_h;
  longint cfg_mx;
  longint m_sums [OUT_W];
  longint m_total;
  int     m_ab, m_lat, m_last;
  int     run_lat;
  int     edges, wcount, hl;
  vec_t   tbl [12];
  vec_t   e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  task automatic load();
    for (int v = 0; v < SEQ_DEPTH; v++) begin
      in_seq[v]   = in_v[v];
      exp_seq[v]  = exp_v[v];
      mask_seq[v] = mask_v[v];
    end
    seq_count = SEQ_W'(cfg_n);
    hold      = 16'(cfg_h);
    max_err   = TOT_W'(cfg_mx);
  endtask

  // Phenotype stand-in: c counts cycles after the start edge; only HOLD cycles carry meaningful data.
  function automatic logic [7:0] circ_value(input int c);
    int h1, rel, v, p;
    h1 = (cfg_h == 0) ? 1 : cfg_h;
    if (c < 1) return 8'($urandom);
    rel = c - 1;
    v   = rel / (h1 + 1);
    p   = rel % (h1 + 1) - 1;
    if (p >= 0 && v < cfg_n) return exp_v[v] ^ corrupt[v][p];
    return 8'($urandom);
  endfunction

  task automatic model();
    int  h1, vd;
    logic f;
    h1 = (cfg_h == 0) ? 1 : cfg_h;
    for (int b = 0; b < OUT_W; b++) m_sums[b] = 0;
    m_total = 0;
    m_ab    = 0;
    vd      = 0;
    for (int v = 0; v < cfg_n; v++) begin
      for (int b = 0; b < OUT_W; b++) begin
        f = 1'b0;
        for (int p = IGN; p < h1; p++) f = f | (corrupt[v][p][b] & mask_v[v][b]);
        if (f && m_sums[b] < SAT) m_sums[b] = m_sums[b] + 1;
      end
      m_total = 0;
      for (int b = 0; b < OUT_W; b++) m_total = m_total + m_sums[b];
      vd = v + 1;
      if (cfg_mx != 0 && m_total >= cfg_mx) begin
        m_ab = 1;
        break;
      end
    end
    m_lat  = 1 + vd * (1 + h1);
    m_last = vd - 1;
  endtask

  task automatic run();
    load();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    run_lat = -1;
    for (int c = 0; c < 3000; c++) begin
      circ_out = circ_value(c);
      @(posedge clk); #1;
      if (done) begin
        run_lat = c + 1;
        break;
      end
    end
  endtask

  task automatic do_ack();
    @(negedge clk);
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic verify(input string tag);
    check($sformatf("%s latency", tag), 64'(run_lat), 64'(m_lat));
    check($sformatf("%s done", tag), 64'(done), 64'd1);
    check($sformatf("%s aborted", tag), 64'(aborted), 64'(m_ab));
    for (int b = 0; b < OUT_W; b++)
      check($sformatf("%s sum[%0d]", tag, b), 64'(sums[b]), 64'(m_sums[b]));
    check($sformatf("%s total", tag), 64'(total), 64'(m_total));
    if (m_last >= 0)
      check($sformatf("%s circuit_in", tag), 64'(circ_in), 64'(in_v[m_last]));
    do_ack();
    check($sformatf("%s ready_after_ack", tag), 64'(ready), 64'd1);
    check($sformatf("%s total_retained", tag), 64'(total), 64'(m_total));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; ack = 1'b0; hold = '0; seq_count = '0; max_err = '0;
    in_seq = '0; exp_seq = '0; mask_seq = '0; circ_out = '0;
    cfg_n = 0; cfg_h = 0; cfg_mx = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 64'(ready), 64'd1);
    check("reset done", 64'(done), 64'd0);
    check("reset state", 64'(state), 64'd0);
    check("reset total", 64'(total), 64'd0);
    check("reset circuit_in", 64'(circ_in), 64'd0);
    check("reset clear", 64'(circ_clear), 64'd0);
    check("reset aborted", 64'(aborted), 64'd0);
    check("reset trace_addr", 64'(trace_addr), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // n, h, max, inj_vec, lo, hi, bits, mask, e_bits, e_sum, e_total, e_ab, e_lat, e_last
    tbl[0]  = '{4, 10, 0, -1, 0, -1, 8'h00, 8'hFF, 8'h00, 0, 0,  0, 45, 3};
    tbl[1]  = '{4, 10, 0,  2, 0,  9, 8'h08, 8'hFF, 8'h08, 1, 1,  0, 45, 3};
    tbl[2]  = '{4, 10, 0,  0, 0,  4, 8'h20, 8'hFF, 8'h00, 0, 0,  0, 45, 3};
    tbl[3]  = '{4, 10, 0,  0, 5,  5, 8'h20, 8'hFF, 8'h20, 1, 1,  0, 45, 3};
    tbl[4]  = '{4, 10, 0, -1, 0,  9, 8'h01, 8'hFE, 8'h00, 0, 0,  0, 45, 3};
    tbl[5]  = '{4, 10, 2, -1, 0,  9, 8'hFF, 8'hFF, 8'hFF, 1, 8,  1, 12, 0};
    tbl[6]  = '{3,  0, 0, -1, 0,  9, 8'hFF, 8'hFF, 8'h00, 0, 0,  0,  7, 2};
    tbl[7]  = '{4, 10, 0,  3, 9,  9, 8'h80, 8'hFF, 8'h80, 1, 1,  0, 45, 3};
    tbl[8]  = '{4, 10, 0, -1, 0,  9, 8'hFF, 8'hFF, 8'hFF, 4, 32, 0, 45, 3};
    tbl[9]  = '{4, 10, 9, -1, 0,  9, 8'hFF, 8'hFF, 8'hFF, 2, 16, 1, 23, 1};
    tbl[10] = '{0, 10, 0, -1, 0,  9, 8'hFF, 8'hFF, 8'h00, 0, 0,  0,  1, -1};
    tbl[11] = '{2,  6, 0,  1, 5,  5, 8'h03, 8'hFF, 8'h03, 1, 2,  0, 15, 1};

    for (int i = 0; i < 12; i++) begin
      e = tbl[i];
      cfg_n = e.n; cfg_h = e.h; cfg_mx = e.mx;
      for (int v = 0; v < SEQ_DEPTH; v++) begin
        in_v[v]   = 8'($urandom);
        exp_v[v]  = 8'($urandom);
        mask_v[v] = e.mask;
        for (int p = 0; p < MAXH; p++)
          corrupt[v][p] = ((e.inj_vec < 0 || e.inj_vec == v) && p >= e.lo && p <= e.hi) ? e.bits : 8'h00;
      end
      for (int b = 0; b < OUT_W; b++) m_sums[b] = e.e_bits[b] ? longint'(e.e_sum) : 0;
      m_total = e.e_total; m_ab = e.e_ab; m_lat = e.e_lat; m_last = e.e_last;
      run();
      verify($sformatf("tbl%0d", i));
    end

    // Zero-length run: one CLEAR pulse, then straight to DONE with cleared sums.
    cfg_n = 0; cfg_h = 4; cfg_mx = 0;
    load();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    check("seq0 clear_pulse", 64'(circ_clear), 64'd1);
    check("seq0 state_clear", 64'(state), 64'd1);
    @(posedge clk); #1;
    check("seq0 clear_drop", 64'(circ_clear), 64'd0);
    check("seq0 done", 64'(done), 64'd1);
    check("seq0 total", 64'(total), 64'd0);
    do_ack();
    check("seq0 ready", 64'(ready), 64'd1);

    for (int r = 0; r < 12; r++) begin
      cfg_n  = $urandom_range(0, 8);
      cfg_h  = $urandom_range(0, 12);
      cfg_mx = ($urandom_range(0, 2) == 0) ? 0 : longint'($urandom_range(1, 40));
      for (int v = 0; v < SEQ_DEPTH; v++) begin
        in_v[v]   = 8'($urandom);
        exp_v[v]  = 8'($urandom);
        mask_v[v] = 8'($urandom | $urandom);
        for (int p = 0; p < MAXH; p++) corrupt[v][p] = 8'($urandom & $urandom & $urandom);
      end
      model();
      run();
      verify($sformatf("rnd%0d", r));
    end

    // iStart and iAck held high the whole run: only the IDLE start and the DONE ack take effect.
    cfg_n = 2; cfg_h = 3; cfg_mx = 0;
    for (int v = 0; v < SEQ_DEPTH; v++) begin
      exp_v[v] = 8'h5A; mask_v[v] = 8'hFF; in_v[v] = 8'($urandom);
    end
    load();
    circ_out = 8'h5A;
    @(negedge clk); start = 1'b1; ack = 1'b1;
    @(posedge clk);
    edges = -1;
    for (int k = 1; k < 200; k++) begin
      @(posedge clk); #1;
      if (done) begin
        edges = k;
        break;
      end
    end
    start = 1'b0;
    check("held latency", 64'(edges), 64'd9);
    check("held total", 64'(total), 64'd0);
    @(posedge clk); #1;
    ack = 1'b0;
    check("held ready", 64'(ready), 64'd1);

    // Reset in the middle of vector 1's HOLD window.
    cfg_n = 4; cfg_h = 10; cfg_mx = 0;
    for (int v = 0; v < SEQ_DEPTH; v++) begin
      exp_v[v] = 8'h00; mask_v[v] = 8'hFF;
      for (int p = 0; p < MAXH; p++) corrupt[v][p] = 8'hFF;
    end
    load();
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int c = 0; c < 20; c++) begin
      circ_out = circ_value(c);
      @(posedge clk); #1;
    end
    check("midrun state_hold", 64'(state), 64'd3);
    check("midrun total", 64'(total), 64'd8);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("rst ready", 64'(ready), 64'd1);
    check("rst state", 64'(state), 64'd0);
    check("rst total", 64'(total), 64'd0);
    check("rst circuit_in", 64'(circ_in), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst stays_idle", 64'(ready), 64'd1);

    // Trace stream: N=2, H=3, two runs so the address restart is exercised.
    cfg_n = 2; cfg_h = 3; cfg_mx = 0;
    for (int v = 0; v < SEQ_DEPTH; v++) begin
      in_v[v] = 8'($urandom); exp_v[v] = 8'($urandom); mask_v[v] = 8'hFF;
      for (int p = 0; p < MAXH; p++) corrupt[v][p] = 8'h00;
    end
    for (int r = 0; r < 2; r++) begin
      load();
      wcount = 0;
      @(negedge clk); start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int c = 0; c < 40; c++) begin
        circ_out = circ_value(c);
        #1;
`ifdef CHROM_EVAL_TRACE_EN
        if (trace_wr) begin
          hl = wcount / 3;
          check($sformatf("trace%0d addr", r), 64'(trace_addr), 64'(wcount));
          check($sformatf("trace%0d f_in", r), 64'(trace_data[31:24]), 64'(in_v[hl]));
          check($sformatf("trace%0d f_idx", r), 64'(trace_data[23:16]), 64'(hl));
          check($sformatf("trace%0d f_exp", r), 64'(trace_data[15:8]), 64'(exp_v[hl]));
          check($sformatf("trace%0d f_out", r), 64'(trace_data[7:0]), 64'(circ_out));
          wcount++;
        end
`else
        check($sformatf("notrace%0d wr", r), 64'(trace_wr), 64'd0);
        check($sformatf("notrace%0d addr", r), 64'(trace_addr), 64'd0);
        check($sformatf("notrace%0d data", r), 64'(trace_data), 64'd0);
`endif
        if (done) break;
        @(posedge clk); #1;
      end
`ifdef CHROM_EVAL_TRACE_EN
      check($sformatf("trace%0d writes", r), 64'(wcount), 64'd6);
`endif
      check($sformatf("trace%0d done", r), 64'(done), 64'd1);
      do_ack();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
